// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Passive read-back of a multiplexed, active-low seven-segment display. The
// anode and segment pins are sampled every cycle; once a single-digit pattern
// has been seen unchanged for STABLE_CYCLES consecutive samples it is decoded
// back into a hex nibble plus decimal point and stored in that digit's slot.
//
// Ports
//   input_clock  system clock, all logic on the rising edge
//   reset_n      synchronous active-low reset (dominates clear)
//   seg[7:0]     segment lines, active-low; bit0=a .. bit6=g, bit7=dp
//   anode[3:0]   digit enables, active-low; anode[i]=0 selects digit i
//   clear        clears valid/blank/err/multi_err and the frame mask
//   digits[15:0] decoded nibbles, digit i at [4i+3:4i]
//   dp[3:0]      decoded decimal point per digit (1 = lit)
//   valid[3:0]   digit i holds a legal hex decode
//   blank[3:0]   digit i was captured with segments a-g all off
//   err[3:0]     sticky, digit i was captured with a non-hex pattern
//   multi_err    sticky, two or more anodes were seen low together
//   frame_done   one-cycle pulse once all four digits have been captured
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        input_clock,
    input  logic        reset_n,
    input  logic [7:0]  seg,
    input  logic [3:0]  anode,
    input  logic        clear,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  valid,
    output logic [3:0]  blank,
    output logic [3:0]  err,
    output logic        multi_err,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRACK    = 2'd1,
        CAPTURED = 2'd2
    } state_t;

    // The counter holds "samples seen equal minus one", so a capture fires
    // when the sample has been identical STABLE_CYCLES times in a row.
    localparam logic [7:0] CAP_CNT = 8'(STABLE_CYCLES - 1);

    // Returns {legal, nibble} for an active-high gfedcba pattern.
    function automatic logic [4:0] hex_decode(input logic [6:0] p);
        case (p)
            7'h3F:   return {1'b1, 4'h0};
            7'h06:   return {1'b1, 4'h1};
            7'h5B:   return {1'b1, 4'h2};
            7'h4F:   return {1'b1, 4'h3};
            7'h66:   return {1'b1, 4'h4};
            7'h6D:   return {1'b1, 4'h5};
            7'h7D:   return {1'b1, 4'h6};
            7'h07:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h6F:   return {1'b1, 4'h9};
            7'h77:   return {1'b1, 4'hA};
            7'h7C:   return {1'b1, 4'hB};
            7'h39:   return {1'b1, 4'hC};
            7'h5E:   return {1'b1, 4'hD};
            7'h79:   return {1'b1, 4'hE};
            7'h71:   return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

    function automatic logic [2:0] count_zeros(input logic [3:0] a);
        return {2'b00, ~a[0]} + {2'b00, ~a[1]} + {2'b00, ~a[2]} + {2'b00, ~a[3]};
    endfunction

    // Only meaningful when exactly one bit is low.
    function automatic logic [1:0] low_index(input logic [3:0] a);
        if (!a[0]) return 2'd0;
        if (!a[1]) return 2'd1;
        if (!a[2]) return 2'd2;
        return 2'd3;
    endfunction

    state_t      state_q, state_d;
    logic [11:0] samp_q, samp_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  dp_q, dp_d;
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  blank_q, blank_d;
    logic [3:0]  err_q, err_d;
    logic [3:0]  mask_q, mask_d;
    logic        multi_err_q, multi_err_d;
    logic        frame_done_q, frame_done_d;

    logic [3:0]  anode_s;
    logic [7:0]  seg_s;
    logic [2:0]  zeros;
    logic        one_hot;
    logic        capture;
    logic [1:0]  idx;
    logic [4:0]  dec;

    always_comb begin
        samp_d = {anode, seg};
        if (samp_d != samp_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q == 8'hFF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        anode_s = samp_q[11:8];
        seg_s   = samp_q[7:0];
        zeros   = count_zeros(anode_s);
        one_hot = (zeros == 3'd1);
        idx     = low_index(anode_s);
        dec     = hex_decode(~seg_s[6:0]);

        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (one_hot) state_d = TRACK;
            end
            TRACK: begin
                if (!one_hot) begin
                    state_d = IDLE;
                end else if (cnt_q == CAP_CNT) begin
                    capture = 1'b1;
                    state_d = CAPTURED;
                end
            end
            CAPTURED: begin
                // A zero count means the sample just changed.
                if (cnt_q == 8'd0) state_d = one_hot ? TRACK : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A full mask is reported one cycle later and restarts from empty on
        // that edge; a capture landing on the same edge is merged in below.
        frame_done_d = (mask_q == 4'hF);
        mask_d       = (clear || frame_done_d) ? 4'h0 : mask_q;
        valid_d      = clear ? 4'h0 : valid_q;
        blank_d      = clear ? 4'h0 : blank_q;
        err_d        = clear ? 4'h0 : err_q;
        multi_err_d  = (clear ? 1'b0 : multi_err_q) | (zeros >= 3'd2);
        digits_d     = digits_q;
        dp_d         = dp_q;

        // Capture writes come after clear so they win for their digit.
        if (capture) begin
            dp_d[idx]   = ~seg_s[7];
            mask_d[idx] = 1'b1;
            if (dec[4]) begin
                digits_d[{idx, 2'b00} +: 4] = dec[3:0];
                valid_d[idx] = 1'b1;
                blank_d[idx] = 1'b0;
            end else if (seg_s[6:0] == 7'h7F) begin
                valid_d[idx] = 1'b0;
                blank_d[idx] = 1'b1;
            end else begin
                err_d[idx]   = 1'b1;
                valid_d[idx] = 1'b0;
                blank_d[idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge input_clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            samp_q       <= 12'hFFF;
            cnt_q        <= 8'd0;
            digits_q     <= 16'h0000;
            dp_q         <= 4'h0;
            valid_q      <= 4'h0;
            blank_q      <= 4'h0;
            err_q        <= 4'h0;
            mask_q       <= 4'h0;
            multi_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            samp_q       <= samp_d;
            cnt_q        <= cnt_d;
            digits_q     <= digits_d;
            dp_q         <= dp_d;
            valid_q      <= valid_d;
            blank_q      <= blank_d;
            err_q        <= err_d;
            mask_q       <= mask_d;
            multi_err_q  <= multi_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digits     = digits_q;
    assign dp         = dp_q;
    assign valid      = valid_q;
    assign blank      = blank_q;
    assign err        = err_q;
    assign multi_err  = multi_err_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receive-side counterpart of the multiplexed seven-segment display driver. The block passively samples active-low segment and anode lines and waits for each digit pattern to settle. It then decodes the pattern back to a hex nibble plus decimal point and holds a per-digit value register. It is used on the board loopback and in benches to read back what the display is actually showing.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (legal range 2..255).

Ports:
input_clock  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous active-low reset
seg  input  8  segment lines, active-low; bit0=a … bit6=g, bit7=dp
anode  input  4  digit enables, active-low; anode[i]=0 selects digit i
clear  input  1  synchronous clear of valid/blank/err/multi_err and the frame mask
digits  output  16  decoded nibbles; digit i at [4i+3:4i]
dp  output  4  decoded decimal point per digit (1 = lit)
valid  output  4  digit i holds a legal hex decode
blank  output  4  digit i captured with all a–g off
err  output  4  sticky; digit i captured with a non-hex pattern
multi_err  output  1  sticky; more than one anode low seen
frame_done  output  1  one-cycle pulse when all four digits captured since last pulse

Behaviour:
- Reset (reset_n=0 at an edge): digits=0, dp=0, valid=0, blank=0, err=0, multi_err=0, frame_done=0, frame mask=0, stability counter=0, state=IDLE, sample register=8'hFF/4'hF. Reset dominates clear. Reset mid-capture discards the partial count.
- Input stage: {anode,seg} registered once every cycle into sample S. Counter cnt (8 bit) is 0 when S differs from previous S, otherwise it increments, saturating at 255.
- States:
  - IDLE: no anode low, or anode value illegal. Go to TRACK when S.anode has exactly one zero bit.
  - TRACK: if anode is no longer one-hot-low, go to IDLE. If S changes, stay in TRACK with cnt=0. When cnt==STABLE_CYCLES-1, capture into digit i = index of the low anode bit and go to CAPTURED.
  - CAPTURED: hold. Any change in S goes to TRACK (or IDLE if anode is not one-hot-low). No re-capture while S stays constant.
- Capture of digit i, registered, visible the cycle after the capture edge:
  - dp[i] = ~seg[7].
  - Map p = ~seg[6:0] (gfedcba, active-high): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
  - Legal hex pattern: digits[i]=nibble, valid[i]=1, blank[i]=0.
  - p==00: blank[i]=1, valid[i]=0, digits[i] unchanged, err unchanged.
  - Any other pattern: err[i]=1 (sticky), valid[i]=0, blank[i]=0, digits[i] unchanged.
  - Set frame mask bit i.
- Latency: the new value appears on the outputs STABLE_CYCLES+1 rising edges after the first edge at which the pins carry the new settled value.
- frame_done: high for exactly one cycle, the cycle after the capture that makes the mask 4'b1111. The mask clears in the same edge. A capture on that same edge is not lost: its bit is set in the freshly cleared mask.
- multi_err: set whenever S.anode has two or more zero bits. No capture happens in that case.
- clear=1: valid, blank, err, multi_err and the frame mask go to 0 next edge. digits and dp are kept. If a capture coincides with clear, the capture's flag writes win for that digit.
- Glitch rule: any single-cycle difference in S restarts the count. A pattern held for STABLE_CYCLES-1 cycles is never captured.

Test Plan:
- STABLE_CYCLES=4. Reset, then seg=8'hC0, anode=4'b1110 held → 5 edges later: digits[3:0]=0, valid=4'b0001, dp[0]=0. No frame_done.
- Scan digits 0..3 with seg 8'hF9, 8'h24, 8'h30, 8'h19 (1,2,3,4), 6 cycles each → digits=16'h4321, valid=4'hF, frame_done pulses once, 1 cycle after the digit-3 capture.
- Anode 4'b1101 with seg toggling every 3 cycles for 30 cycles → no capture, valid[1]=0.
- seg=8'h7F on digit 2 → blank[2]=1, valid[2]=0, dp[2]=1. seg=8'hFE (segment a only) on digit 3 → err[3]=1, digits[15:12] unchanged. Pulse clear → err=0, blank=0.
- anode=4'b1100 for 10 cycles → multi_err=1, no flags change. Then reset_n=0 for one edge during a digit-0 track → all outputs 0 and no capture follows.
- STABLE_CYCLES=2: pattern held exactly 1 cycle → ignored. Held 2 cycles → captured 3 edges after settle.
